// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: widths, reset PC, NOP encoding,
// fetch FSM state encodings and small PC helpers.
package pc_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] CPU_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] CPU_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_skid.sv
// One-entry skid register holding an instruction that returned from IMEM
// while IF/ID could not accept it.
module fetch_skid_buffer
  import pc_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid
);

  // Occupancy flag: clear (reset or flush) beats load, load beats pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // Payload only matters while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, issues IMEM reads, handles
// load-use holds, global memory stalls, EX redirects and wrong-path drains.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            LU_HAZ_SIG,
  input  logic            DMEM_BUSY,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic            IMEM_READ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_BUSY,
  input  logic [XLEN-1:0] IMEM_INSTR,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_INSTR,
  output logic            IFID_VALID,
  output logic            IF_STALL
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] ifid_pc_p1;
  logic [XLEN-1:0] ifid_instr_p1;
  logic            vld_p1;

  logic            skid_load;
  logic            skid_pop;
  logic            skid_clear;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;
  logic            skid_valid;

  logic            access_busy;
  logic            resp;
  logic            fetch_resp;
  logic [XLEN-1:0] branch_tgt;

  // In DRAIN the PC still holds the address of the abandoned access, so the
  // IMEM address stays stable until the wrong-path response arrives.
  assign IMEM_READ   = !RESET && ((state == DRAIN) || !skid_valid);
  assign IMEM_ADDR   = pc_p0;
  assign access_busy = IMEM_READ && IMEM_BUSY;
  assign resp        = IMEM_READ && !IMEM_BUSY;
  assign fetch_resp  = resp && (state == FETCH);
  assign branch_tgt  = word_align(BRANCH_TARGET);
  assign IF_STALL    = access_busy || (state == DRAIN);

  assign IFID_PC    = ifid_pc_p1;
  assign IFID_INSTR = ifid_instr_p1;
  assign IFID_VALID = vld_p1;

  // Skid control: capture a good response whenever IF/ID is held, drain it
  // into IF/ID on the next free cycle, drop it on a redirect.
  always_comb begin
    skid_clear = !RESET && !DMEM_BUSY && BRANCH_TAKEN;
    skid_load  = !RESET && fetch_resp && !skid_valid &&
                 (DMEM_BUSY || (!BRANCH_TAKEN && LU_HAZ_SIG));
    skid_pop   = !RESET && !DMEM_BUSY && !BRANCH_TAKEN && !LU_HAZ_SIG && skid_valid;
  end

  fetch_skid_buffer u_skid (
    .clk        (CLK),
    .rst        (RESET),
    .load       (skid_load),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .load_pc    (pc_p0),
    .load_instr (IMEM_INSTR),
    .pc         (skid_pc),
    .instr      (skid_instr),
    .valid      (skid_valid)
  );

  // Fetch FSM, PC and IF/ID update in priority RESET > DMEM_BUSY > branch > load-use > advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= FETCH;
      pc_p0         <= RESET_PC;
      redir_pc      <= '0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP_INSTR;
      vld_p1        <= 1'b0;
    end else if (DMEM_BUSY) begin
      // EX is frozen, so a branch will re-present; only IMEM traffic moves.
      if (state == FETCH) begin
        if (skid_load) pc_p0 <= pc_next(pc_p0);
      end else if (!IMEM_BUSY) begin
        pc_p0 <= redir_pc;
        state <= FETCH;
      end
    end else if (BRANCH_TAKEN) begin
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP_INSTR;
      vld_p1        <= 1'b0;
      if ((state == FETCH) && access_busy) begin
        redir_pc <= branch_tgt;
        state    <= DRAIN;
      end else if ((state == DRAIN) && IMEM_BUSY) begin
        redir_pc <= branch_tgt;
      end else begin
        pc_p0 <= branch_tgt;
        state <= FETCH;
      end
    end else begin
      // A DRAIN response is wrong-path: discard it and take the redirect.
      if ((state == DRAIN) && !IMEM_BUSY) begin
        pc_p0 <= redir_pc;
        state <= FETCH;
      end
      if (LU_HAZ_SIG) begin
        if (skid_load) pc_p0 <= pc_next(pc_p0);
      end else if (skid_valid) begin
        ifid_pc_p1    <= skid_pc;
        ifid_instr_p1 <= skid_instr;
        vld_p1        <= 1'b1;
      end else if (fetch_resp) begin
        ifid_pc_p1    <= pc_p0;
        ifid_instr_p1 <= IMEM_INSTR;
        vld_p1        <= 1'b1;
        pc_p0         <= pc_next(pc_p0);
      end else begin
        ifid_instr_p1 <= NOP_INSTR;
        vld_p1        <= 1'b0;
      end
    end
  end

endmodule
